// File: rtl/fp16_align_stage.sv
// rtl/fp16_align_stage.sv - fp16 exponent-alignment stage; optional sticky accumulation via ALIGN_STICKY_EN
module fp16_align_stage #(
    parameter int SHAMT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [13:0] mant_big,
    output logic [13:0] mant_small,
    output logic [4:0]  exp_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic [3:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SHAMT_CAP = 4'(SHAMT_MAX);

    state_t      state;
    logic [3:0]  cnt;

    logic [4:0]  eexp_a;
    logic [4:0]  eexp_b;
    logic [4:0]  eexp_big;
    logic [4:0]  eexp_small;
    logic [4:0]  exp_diff;
    logic        a_is_big;
    logic [15:0] op_big;
    logic [15:0] op_small;
    logic [13:0] mant_big_d;
    logic [13:0] mant_small_d;
    logic [3:0]  shamt_d;
    logic [13:0] small_shifted;

    // Decode both operands, order them, and compute the clamped shift amount
    always_comb begin
        eexp_a       = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
        eexp_b       = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
        a_is_big     = (eexp_a > eexp_b) || ((eexp_a == eexp_b) && (a[9:0] >= b[9:0]));
        op_big       = a_is_big ? a : b;
        op_small     = a_is_big ? b : a;
        eexp_big     = a_is_big ? eexp_a : eexp_b;
        eexp_small   = a_is_big ? eexp_b : eexp_a;
        exp_diff     = eexp_big - eexp_small;
        mant_big_d   = {(op_big[14:10] != 5'd0), op_big[9:0], 3'b000};
        mant_small_d = {(op_small[14:10] != 5'd0), op_small[9:0], 3'b000};
        shamt_d      = (exp_diff > {1'b0, SHAMT_CAP}) ? SHAMT_CAP : exp_diff[3:0];
    end

    // One-bit right shift of the small mantissa per SHIFT cycle
    always_comb begin
`ifdef ALIGN_STICKY_EN
        small_shifted = {1'b0, mant_small[13:2], mant_small[1] | mant_small[0]};
`else
        small_shifted = {1'b0, mant_small[13:1]};
`endif
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Control FSM: accept a pair, shift shamt times, hold the result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            mant_big   <= 14'd0;
            mant_small <= 14'd0;
            exp_out    <= 5'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            shamt      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_big   <= mant_big_d;
                        mant_small <= mant_small_d;
                        exp_out    <= eexp_big;
                        sign_big   <= op_big[15];
                        sign_small <= op_small[15];
                        shamt      <= shamt_d;
                        cnt        <= shamt_d;
                        state      <= (shamt_d != 4'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    mant_small <= small_shifted;
                    cnt        <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_align_stage.sv
// tb/tb_fp16_align_stage.sv - randomized model-checked bench for fp16_align_stage
module tb_fp16_align_stage;

    localparam int SHAMT_MAX = 15;

    typedef struct packed {
        logic [13:0] mb;
        logic [13:0] ms;
        logic [4:0]  e;
        logic        sb;
        logic        ss;
        logic [3:0]  sh;
    } res_t;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] mant_big;
    logic [13:0] mant_small;
    logic [4:0]  exp_out;
    logic        sign_big;
    logic        sign_small;
    logic [3:0]  shamt;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    res_t got;
    res_t cur;
    int   phase   = 0;
    int   wait_n  = 0;
    bit   started = 0;
    bit   zero_exp = 0;

    fp16_align_stage #(.SHAMT_MAX(SHAMT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_big  (mant_big),
        .mant_small(mant_small),
        .exp_out   (exp_out),
        .sign_big  (sign_big),
        .sign_small(sign_small),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: alignment result from plain integer arithmetic
    function automatic res_t model_align(input logic [15:0] x, input logic [15:0] y);
        res_t        r;
        int          ex, ey, fx, fy, eb, es, s, mb_i, ms_i;
        bit          x_big;
        logic [15:0] bg, sm;
        ex    = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
        ey    = (y[14:10] == 5'd0) ? 1 : int'(y[14:10]);
        fx    = int'(x[9:0]);
        fy    = int'(y[9:0]);
        x_big = (ex > ey) || (ex == ey && fx >= fy);
        bg    = x_big ? x : y;
        sm    = x_big ? y : x;
        eb    = x_big ? ex : ey;
        es    = x_big ? ey : ex;
        mb_i  = ((bg[14:10] != 5'd0) ? 8192 : 0) + int'(bg[9:0]) * 8;
        ms_i  = ((sm[14:10] != 5'd0) ? 8192 : 0) + int'(sm[9:0]) * 8;
        s     = (eb - es > SHAMT_MAX) ? SHAMT_MAX : eb - es;
        r.mb  = 14'(mb_i);
        r.ms  = 14'(ms_i >> s);
`ifdef ALIGN_STICKY_EN
        if ((ms_i % (1 << s)) != 0) r.ms[0] = 1'b1;
`endif
        r.e   = 5'(eb);
        r.sb  = bg[15];
        r.ss  = sm[15];
        r.sh  = 4'(s);
        return r;
    endfunction

    function automatic logic [15:0] rand_op(input logic [15:0] other);
        logic [15:0] v;
        int          mode;
        v    = 16'($urandom);
        mode = $urandom_range(0, 5);
        case (mode)
            1: v[14:10] = other[14:10];
            2: v = other;
            3: v[14:10] = 5'd0;
            4: v[14:10] = 5'($urandom_range(27, 31));
            5: v[14:10] = 5'(int'(other[14:10]) ^ $urandom_range(0, 3));
            default: ;
        endcase
        return v;
    endfunction

    // Compare process: checks DUT against the protocol/result model every cycle, then advances the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("in_ready", 32'(in_ready), 32'(phase == 0));
                check("out_valid", 32'(out_valid), 32'(phase == 2));
                if (phase != 0) begin
                    check("mant_big", 32'(mant_big), 32'(cur.mb));
                    check("exp_out", 32'(exp_out), 32'(cur.e));
                    check("sign_big", 32'(sign_big), 32'(cur.sb));
                    check("sign_small", 32'(sign_small), 32'(cur.ss));
                    check("shamt", 32'(shamt), 32'(cur.sh));
                end
                if (phase == 2) begin
                    check("mant_small", 32'(mant_small), 32'(cur.ms));
                end
                if (phase == 0 && zero_exp) begin
                    check("reset_outputs",
                          32'({mant_big, mant_small, exp_out, sign_big, sign_small, shamt} != 39'd0), 32'd0);
                end
            end
            if (rst) begin
                phase    = 0;
                zero_exp = 1;
                started  = 1;
            end else if (started) begin
                case (phase)
                    0: if (in_valid) begin
                        cur      = model_align(a, b);
                        zero_exp = 0;
                        if (cur.sh == 4'd0) phase = 2;
                        else begin
                            phase  = 1;
                            wait_n = int'(cur.sh);
                        end
                    end
                    1: begin
                        wait_n--;
                        if (wait_n == 0) phase = 2;
                    end
                    2: if (out_ready) phase = 0;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Drive one pair; hold < 0 means out_ready is already high when the result appears
    task automatic run_job(input logic [15:0] x, input logic [15:0] y, input int hold);
        int n;
        a = x;
        b = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'($urandom_range(0, 1));
        a         = 16'($urandom);
        b         = 16'($urandom);
        out_ready = (hold < 0);
        n = 0;
        @(negedge clk);
        while (!out_valid) begin
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL valid_timeout: out_valid stayed 0 for %0d cycles", n);
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        got = {mant_big, mant_small, exp_out, sign_big, sign_small, shamt};
        @(posedge clk);
        #1;
        if (hold >= 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    res_t p;

    initial begin
        rst       = 1'b1;
        a         = 16'd0;
        b         = 16'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        p = model_align(16'h4000, 16'h3C00);
        check("pin_basic", 32'({p.mb, p.ms, p.e, p.sb, p.ss, p.sh}),
              32'({14'h2000, 14'h1000, 5'd16, 1'b0, 1'b0, 4'd1} & 39'h7FFFFFFF));
        check("pin_basic_ms", 32'(p.ms), 32'h1000);
        p = model_align(16'h3C00, 16'hC000);
        check("pin_swap_sign", 32'({p.sb, p.ss}), 32'b10);
        check("pin_swap_ms", 32'(p.ms), 32'h1000);
        p = model_align(16'h3C00, 16'h3C00);
        check("pin_zero_sh", 32'(p.sh), 32'd0);
        check("pin_zero_ms", 32'(p.ms), 32'h2000);
        p = model_align(16'h7800, 16'h3C01);
        check("pin_clamp_sh", 32'(p.sh), 32'd15);
`ifdef ALIGN_STICKY_EN
        check("pin_clamp_ms", 32'(p.ms), 32'h0001);
`else
        check("pin_clamp_ms", 32'(p.ms), 32'h0000);
`endif

        run_job(16'h4000, 16'h3C00, 0);
        check("dut_basic_ms", 32'(got.ms), 32'h1000);
        check("dut_basic_mb", 32'(got.mb), 32'h2000);
        check("dut_basic_exp", 32'(got.e), 32'd16);
        run_job(16'h3C00, 16'hC000, 1);
        check("dut_swap_sb", 32'(got.sb), 32'd1);
        run_job(16'h3C00, 16'h3C00, -1);
        check("dut_zero_ms", 32'(got.ms), 32'h2000);
        run_job(16'h7800, 16'h3C01, 0);
        check("dut_clamp_sh", 32'(got.sh), 32'd15);
`ifdef ALIGN_STICKY_EN
        check("dut_clamp_ms", 32'(got.ms), 32'h0001);
`else
        check("dut_clamp_ms", 32'(got.ms), 32'h0000);
`endif
        run_job(16'h4C00, 16'h4000, 4);
        run_job(16'h4000, 16'h3C00, -1);

        a        = 16'h6400;
        b        = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_mant_small", 32'(mant_small), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        run_job(16'h6400, 16'h3C00, 0);
        check("dut_after_rst_sh", 32'(got.sh), 32'd10);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = rand_op(x);
            if ($urandom_range(0, 1) == 1) run_job(y, x, $urandom_range(0, 5) - 1);
            else run_job(x, y, $urandom_range(0, 5) - 1);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_align_stage.md
FP16_ALIGN_STAGE -- requirements
Module: fp16_align_stage

Interface
REQ-001 SHALL have parameter SHAMT_MAX, default 15, range 1..15: clamp ceiling for the alignment shift.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port a  input  16  IEEE half-precision operand A: sign[15], exp[14:10], frac[9:0].
REQ-005 SHALL have port b  input  16  IEEE half-precision operand B, same layout as a.
REQ-006 SHALL have port in_valid  input  1  a and b are valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-008 SHALL have port mant_big  output  14  larger operand's mantissa as {hidden, frac, G, R, S}.
REQ-009 SHALL have port mant_small  output  14  smaller operand's mantissa, right-aligned to exp_out.
REQ-010 SHALL have port exp_out  output  5  effective exponent of the larger operand.
REQ-011 SHALL have port sign_big  output  1  sign of the larger operand.
REQ-012 SHALL have port sign_small  output  1  sign of the smaller operand.
REQ-013 SHALL have port shamt  output  4  applied shift amount after clamping; drives downstream 16:1 select logic.
REQ-014 SHALL have port out_valid  output  1  all result outputs are valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-016 Field decode SHALL be: hidden = (exp != 0); eexp = (exp == 0) ? 1 : exp; extended mantissa = {hidden, frac, 3'b000}.
REQ-017 Operand ordering SHALL be: big = the operand with the larger eexp; on equal eexp, the operand with the larger frac; on a full tie, a.
REQ-018 Shift amount SHALL be shamt = min(eexp_big - eexp_small, SHAMT_MAX).
REQ-019 States SHALL be IDLE, SHIFT and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-020 Accept SHALL occur when in_valid & in_ready; on the accept edge, decode/order/shamt results are registered, the shift counter loads shamt, and the next state is SHIFT if shamt != 0, else DONE.
REQ-021 In SHIFT, each cycle SHALL shift mant_small right by one bit, insert 0 at the MSB, decrement the counter, and go to DONE when the counter reaches 1.
REQ-022 Latency SHALL be: out_valid asserted exactly 1 + shamt cycles after the accept edge.
REQ-023 In DONE with out_ready = 0, every output SHALL be held stable; with out_ready = 1, the result is consumed and the state returns to IDLE on that edge.
REQ-024 A new pair SHALL never be accepted in the cycle the result is consumed; the earliest next accept is the following cycle.
REQ-025 mant_big, exp_out, both signs and shamt SHALL remain constant from the accept edge until consumption.
REQ-026 Inputs a and b SHALL be ignored outside IDLE; in_valid held high while busy has no effect.
REQ-027 NaN and Inf SHALL get no special handling; they are aligned as ordinary encodings with exp = 31.

Reset
REQ-028 rst = 1 at a clock edge SHALL force IDLE and clear all registered outputs to 0: out_valid = 0, in_ready = 1 in the following cycle.
REQ-029 rst asserted mid-SHIFT or in DONE SHALL discard the in-flight result, with no out_valid pulse afterwards.
REQ-030 rst SHALL take priority over accept and over consume on the same edge.

Configuration
REQ-031 Macro ALIGN_STICKY_EN: when defined, each SHIFT cycle SHALL set new bit0 = old bit1 | old bit0, so sticky accumulates all shifted-out ones.
REQ-032 Without ALIGN_STICKY_EN, each SHIFT cycle SHALL be a plain logical right shift; shifted-out bits are lost and there is no sticky OR logic.

Verification
REQ-033 Basic: a = 0x4000, b = 0x3C00 -> shamt = 1, exp_out = 16, mant_big = 0x2000, mant_small = 0x1000, sign_big = sign_small = 0; out_valid 2 cycles after accept.
REQ-034 Swap: a = 0x3C00, b = 0xC000 -> big = b, sign_big = 1, sign_small = 0, shamt = 1, mant_small = 0x1000.
REQ-035 Zero shift: a = b = 0x3C00 -> shamt = 0, mant_big = mant_small = 0x2000; out_valid on the cycle after accept.
REQ-036 Clamp and sticky: a = 0x7800, b = 0x3C01 -> shamt = 15, 15 SHIFT cycles; mant_small = 0x0001 with ALIGN_STICKY_EN, 0x0000 without.
REQ-037 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, in_valid ignored; consume on the 6th cycle, accept possible on the 7th.
REQ-038 Reset mid-operation: rst pulsed during SHIFT of a shamt = 10 job -> IDLE next cycle, outputs 0, no out_valid; a fresh job then completes correctly.
